// File: rtl/serial_pkg.sv
// serial_pkg: types and constants shared by the SFR serial input and output channels.
package serial_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BRK
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_CLK_DIV   = 434;

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: circular receive buffer with first-word-fall-through head output.
module rx_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rx_fifo: DEPTH must be a power of two >= 2");
    end

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = do_push ? wr_q + (AW + 1)'(1) : wr_q;
        rd_d    = do_pop ? rd_q + (AW + 1)'(1) : rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/serial_in.sv
// serial_in: 8N1 UART receiver for the SFR space with sticky overrun/frame error flags.
// Define SERIAL_IN_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module serial_in
    import serial_pkg::*;
#(
    parameter int CLK_DIV    = UART_CLK_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    input  logic                      rd_en,
    input  logic                      clr_err,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      overrun,
    output logic                      frame_err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

    if (CLK_DIV < 4 || CLK_DIV % 2 != 0) begin : g_bad_div
        $error("serial_in: CLK_DIV must be even and >= 4");
    end
    if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("serial_in: FIFO_DEPTH must be a power of two");
    end

    logic                      sync1_q, rxs_q, prev_q;
    rx_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                      tick, push, frame_evt, ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            rxs_q   <= sync1_q;
            prev_q  <= rxs_q;
        end
    end

    // The timer reloads at every sample; IDLE and BRK hold it at the half-bit value.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_evt = 1'b0;
        tick      = cnt_q == '0;
        cnt_d     = tick ? FULL_M1 : cnt_q - CW'(1);
        case (state_q)
            RX_IDLE: begin
                cnt_d = HALF_M1;
                if (prev_q && !rxs_q) begin
                    state_d = RX_START;
                    bit_d   = '0;
                end
            end
            RX_START: if (tick) state_d = rxs_q ? RX_IDLE : RX_DATA;
            RX_DATA: if (tick) begin
                shift_d = {rxs_q, shift_q[UART_DATA_BITS-1:1]};
                bit_d   = bit_q + BW'(1);
                if (bit_q == LAST_BIT) state_d = RX_STOP;
            end
            RX_STOP: if (tick) begin
                push      = rxs_q;
                frame_evt = !rxs_q;
                state_d   = rxs_q ? RX_IDLE : RX_BRK;
            end
            RX_BRK: begin
                cnt_d = HALF_M1;
                if (rxs_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= HALF_M1;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

`ifdef SERIAL_IN_FIFO_EN
    logic fifo_full, fifo_empty;

    rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(UART_DATA_BITS)
    ) u_rx_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (rd_en),
        .data_i (shift_q),
        .data_o (rx_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign rx_valid = !fifo_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign ovf = push && fifo_full && !rd_en;
`else
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic                      hold_v_q, hold_v_d, take, give;

    always_comb begin
        give     = rd_en && hold_v_q;
        take     = push && (!hold_v_q || give);
        hold_v_d = take || (hold_v_q && !give);
        hold_d   = take ? shift_q : hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end

    assign rx_data  = hold_q;
    assign rx_valid = hold_v_q;
    assign ovf      = push && !take;
`endif

    // A new error event beats a simultaneous clear.
    always_comb begin
        overrun_d   = (overrun_q && !clr_err) || ovf;
        frame_err_d = (frame_err_q && !clr_err) || frame_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_in.sv
// tb_serial_in: directed and random 8N1 frames checked against a transaction-level buffer model.
module tb_serial_in;

    localparam int DIV = 16;
`ifdef SERIAL_IN_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif
    // Pin edge driven at a negedge; two sync flops plus edge detect put the stop sample here.
    localparam int STOP_EDGE = 3 + DIV / 2 + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, overrun, frame_err;

    int         total = 0;
    int         bad = 0;
    logic [7:0] q[$];
    logic       m_ovr = 1'b0;
    logic       m_fe = 1'b0;

    serial_in #(
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rd_en    (rd_en),
        .clr_err  (clr_err),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(rx_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk({tag, ".data"}, 32'(rx_data), 32'(q[0]));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
    endtask

    function automatic void m_push(input logic [7:0] b, input bit pop_same);
        if (pop_same && q.size() > 0) q.delete(0);
        if (q.size() < CAP) q.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int pop_at);
        logic [9:0] f;
        int n;
        f = {stop, b, 1'b0};
        n = 0;
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            for (int k = 0; k < DIV; k++) begin
                @(negedge clk);
                n++;
                rd_en = (n == pop_at);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic pop;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() > 0) q.delete(0);
    endtask

    task automatic clr;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovr = 1'b0;
        m_fe = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset.data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        idle(5);

        send(8'hA5, 1'b1, -1);
        m_push(8'hA5, 1'b0);
        idle(4);
        check_all("a5");
        pop;
        check_all("a5.pop");
        pop;
        check_all("empty.pop");
        chk("empty.pop.data", 32'(rx_data), 32'hA5);

        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check_all("glitch");
        b = 8'($urandom);
        send(b, 1'b1, -1);
        m_push(b, 1'b0);
        idle(4);
        check_all("after_glitch");
        pop;

        send(8'h3C, 1'b0, -1);
        repeat (40) @(negedge clk);
        m_fe = 1'b1;
        idle(6);
        check_all("break");
        send(8'h81, 1'b1, -1);
        m_push(8'h81, 1'b0);
        idle(4);
        check_all("break.81");
        clr;
        check_all("break.clr");
        pop;
        check_all("break.pop");

        for (int v = 1; v <= 5; v++) begin
            send(8'(v), 1'b1, -1);
            m_push(8'(v), 1'b0);
            idle(4);
        end
        check_all("ovr.fill");
        for (int i = 0; i <= CAP; i++) begin
            pop;
            check_all("ovr.drain");
        end

        clr;
        for (int i = 0; i < CAP; i++) begin
            b = 8'($urandom);
            send(b, 1'b1, -1);
            m_push(b, 1'b0);
            idle(4);
        end
        check_all("full");
        send(8'h55, 1'b1, STOP_EDGE - 1);
        m_push(8'h55, 1'b1);
        idle(4);
        check_all("full.pop_push");
        while (q.size() > 0) begin
            pop;
            check_all("full.drain");
        end

        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send(b, ok, -1);
            if (ok) m_push(b, 1'b0);
            else begin
                m_fe = 1'b1;
                repeat ($urandom_range(5, 30)) @(negedge clk);
            end
            idle(4 + $urandom_range(0, 10));
            check_all("rand");
            if ($urandom_range(0, 1) == 1) begin
                pop;
                check_all("rand.pop");
            end
            if ($urandom_range(0, 3) == 0) begin
                clr;
                check_all("rand.clr");
            end
        end

        send(8'hC3, 1'b1, -1);
        m_push(8'hC3, 1'b0);
        send(8'h00, 1'b0, -1);
        m_fe = 1'b1;
        repeat (20) @(negedge clk);
        idle(4);
        check_all("pre_rst");
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        m_fe = 1'b0;
        @(negedge clk);
        check_all("in_rst");
        chk("in_rst.data", 32'(rx_data), 32'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(20);
        check_all("post_rst");
        send(8'h12, 1'b1, -1);
        m_push(8'h12, 1'b0);
        idle(4);
        check_all("post_rst.12");
        pop;
        check_all("post_rst.pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
